if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 31 +++
 rtl/if_stage_pc_reg.sv | 90 +++++++++
 rtl/if_stage.sv | 102 ++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// ============================================================================
//  Module      : if_stage_pkg
//  Description : Shared widths, constants, state encoding and helpers for the
//                instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

  localparam int          C_WORD_W           = 32;
  localparam int          C_STALL_W          = 6;
  localparam logic [31:0] C_ZERO_WORD        = 32'h0000_0000;
  localparam logic        C_CHIP_ENABLE      = 1'b1;
  localparam logic        C_CHIP_DISABLE     = 1'b0;
  localparam logic        C_STOP             = 1'b1;
  localparam logic        C_NO_STOP          = 1'b0;
  localparam logic [31:0] C_DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [C_WORD_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage_pc_reg.sv
// ============================================================================
//  Module      : if_stage_pc_reg
//  Description : Fetch FSM, next-PC selection and pending-branch capture.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [C_WORD_W-1:0] RESET_PC = C_DEFAULT_RESET_PC,
  parameter logic [C_WORD_W-1:0] PC_STEP  = 32'd4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_pc,
  input  logic                flush,
  input  logic [C_WORD_W-1:0] new_pc,
  input  logic                branch_flag_i,
  input  logic [C_WORD_W-1:0] branch_target_address_i,
  output logic [C_WORD_W-1:0] pc,
  output logic                ce
);

  fetch_state_e        state_q, state_d;
  logic [C_WORD_W-1:0] pc_q, pc_d;
  logic [C_WORD_W-1:0] pend_addr_q, pend_addr_d;
  logic                pend_valid_q, pend_valid_d;
  logic                ce_q, ce_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ce_d         = ce_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        ce_d    = C_CHIP_ENABLE;
        pc_d    = RESET_PC;
      end
      ST_FETCH: begin
        if (flush) begin
          pc_d         = new_pc;
          pend_valid_d = 1'b0;
        end else if (stall_pc == C_NO_STOP) begin
          // A branch resolved now is newer than anything parked while stalled.
          pend_valid_d = 1'b0;
          if (branch_flag_i) begin
            pc_d = branch_target_address_i;
          end else if (pend_valid_q) begin
            pc_d = pend_addr_q;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end else if (branch_flag_i) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = branch_target_address_i;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ce_d    = C_CHIP_DISABLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      ce_q         <= C_CHIP_DISABLE;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= C_ZERO_WORD;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ce_q         <= ce_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign pc = pc_q;
  assign ce = ce_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage: PC sequencing, IF/ID register and
//                delivered-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [C_WORD_W-1:0] RESET_PC = C_DEFAULT_RESET_PC,
  parameter logic [C_WORD_W-1:0] PC_STEP  = 32'd4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [C_STALL_W-1:0] stall,
  input  logic                 flush,
  input  logic [C_WORD_W-1:0]  new_pc,
  input  logic                 branch_flag_i,
  input  logic [C_WORD_W-1:0]  branch_target_address_i,
  input  logic [C_WORD_W-1:0]  inst_i,
  output logic [C_WORD_W-1:0]  pc,
  output logic                 ce,
  output logic [C_WORD_W-1:0]  id_pc,
  output logic [C_WORD_W-1:0]  id_inst,
  output logic                 id_misalign,
  output logic [C_WORD_W-1:0]  fetch_count
);

  logic [C_WORD_W-1:0] id_pc_q, id_pc_d;
  logic [C_WORD_W-1:0] id_inst_q, id_inst_d;
  logic                id_misalign_q, id_misalign_d;
  logic [C_WORD_W-1:0] fetch_count_q, fetch_count_d;
  logic                if_load;
  logic                if_bubble;
  logic                pc_misaligned;
  logic [2:0]          unused_stall;

  assign unused_stall = stall[5:3];

  if_stage_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk                     (clk),
    .rst                     (rst),
    .stall_pc                (stall[0]),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .pc                      (pc),
    .ce                      (ce)
  );

  assign pc_misaligned = is_misaligned(pc);
  assign if_bubble     = flush || (stall[1] == C_STOP && stall[2] == C_NO_STOP);
  assign if_load       = !flush && stall[1] == C_NO_STOP;

  always_comb begin
    id_pc_d       = id_pc_q;
    id_inst_d     = id_inst_q;
    id_misalign_d = id_misalign_q;
    fetch_count_d = fetch_count_q;
    if (if_bubble) begin
      id_pc_d       = C_ZERO_WORD;
      id_inst_d     = C_ZERO_WORD;
      id_misalign_d = 1'b0;
    end else if (if_load) begin
      // A misaligned or disabled fetch never delivers real instruction bits.
      id_pc_d       = pc;
      id_inst_d     = (ce && !pc_misaligned) ? inst_i : C_ZERO_WORD;
      id_misalign_d = pc_misaligned;
      if (ce) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc_q       <= C_ZERO_WORD;
      id_inst_q     <= C_ZERO_WORD;
      id_misalign_q <= 1'b0;
      fetch_count_q <= C_ZERO_WORD;
    end else begin
      id_pc_q       <= id_pc_d;
      id_inst_q     <= id_inst_d;
      id_misalign_q <= id_misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign id_pc       = id_pc_q;
  assign id_inst     = id_inst_q;
  assign id_misalign = id_misalign_q;
  assign fetch_count = fetch_count_q;

endmodule

`default_nettype wire
